// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
//
// Frame-level round-robin arbiter that shares the single MAC TX AXI-Stream
// port between two encapsulation streams (port 0: RX-snoop, port 1: TX-snoop).
// A grant is held from the first beat of a frame until its tlast beat is
// accepted, so frames are never interleaved. Everything runs on eth_clk.
//
// Handshake: a beat moves across an interface in a cycle where tvalid and
// tready are both high at the rising edge; a source keeps tvalid and its beat
// stable until that happens. tready may depend combinationally on tvalid
// (here: sN_tready is eth_tx_tready gated by the grant).
//
// Ports:
//   eth_clk, sys_rst156        clock, synchronous active-high reset
//   s0_*, s1_*                 requester streams (tvalid/tready/tdata/tkeep/tlast/tuser)
//   eth_tx_*                   stream to the MAC
//   grant                      one-hot current owner, 2'b00 when idle
//   frame_cnt0, frame_cnt1     frames forwarded per port
//
// Optional feature: define ETH_TX_ARB_STATS_EN to build the per-port frame
// counters (wrap modulo 2^CNT_WIDTH). Without it both counters read 0.

module eth_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    eth_clk,
    input  logic                    sys_rst156,

    input  logic                    s0_tvalid,
    output logic                    s0_tready,
    input  logic [DATA_WIDTH-1:0]   s0_tdata,
    input  logic [DATA_WIDTH/8-1:0] s0_tkeep,
    input  logic                    s0_tlast,
    input  logic                    s0_tuser,

    input  logic                    s1_tvalid,
    output logic                    s1_tready,
    input  logic [DATA_WIDTH-1:0]   s1_tdata,
    input  logic [DATA_WIDTH/8-1:0] s1_tkeep,
    input  logic                    s1_tlast,
    input  logic                    s1_tuser,

    output logic                    eth_tx_tvalid,
    input  logic                    eth_tx_tready,
    output logic [DATA_WIDTH-1:0]   eth_tx_tdata,
    output logic [DATA_WIDTH/8-1:0] eth_tx_tkeep,
    output logic                    eth_tx_tlast,
    output logic                    eth_tx_tuser,

    output logic [1:0]              grant,
    output logic [CNT_WIDTH-1:0]    frame_cnt0,
    output logic [CNT_WIDTH-1:0]    frame_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   arbitrate;

    always_ff @(posedge eth_clk) begin
        if (sys_rst156) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;   // port 0 wins the first contention
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        arbitrate     = 1'b0;
        eth_tx_tvalid = 1'b0;
        eth_tx_tdata  = '0;
        eth_tx_tkeep  = '0;
        eth_tx_tlast  = 1'b0;
        eth_tx_tuser  = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;

        case (state_q)
            IDLE: arbitrate = 1'b1;
            GNT0: begin
                eth_tx_tvalid = s0_tvalid;
                eth_tx_tdata  = s0_tdata;
                eth_tx_tkeep  = s0_tkeep;
                eth_tx_tlast  = s0_tlast;
                eth_tx_tuser  = s0_tuser;
                s0_tready     = eth_tx_tready;
                // Re-arbitrate in the tlast handshake cycle: no idle bubble.
                arbitrate     = s0_tvalid & eth_tx_tready & s0_tlast;
            end
            GNT1: begin
                eth_tx_tvalid = s1_tvalid;
                eth_tx_tdata  = s1_tdata;
                eth_tx_tkeep  = s1_tkeep;
                eth_tx_tlast  = s1_tlast;
                eth_tx_tuser  = s1_tuser;
                s1_tready     = eth_tx_tready;
                arbitrate     = s1_tvalid & eth_tx_tready & s1_tlast;
            end
            default: state_d = IDLE;
        endcase

        // The finishing port's own tvalid is still high during its tlast
        // handshake, so it competes too; last_gnt already names it, which
        // hands the next frame to the other port when both are waiting.
        if (arbitrate) begin
            if (s0_tvalid && s1_tvalid) begin
                if (last_gnt_q) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                end else begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                end
            end else if (s0_tvalid) begin
                state_d    = GNT0;
                last_gnt_d = 1'b0;
            end else if (s1_tvalid) begin
                state_d    = GNT1;
                last_gnt_d = 1'b1;
            end else begin
                state_d    = IDLE;
            end
        end
    end

    assign grant = {state_q == GNT1, state_q == GNT0};

`ifdef ETH_TX_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt0_q, frame_cnt0_d;
    logic [CNT_WIDTH-1:0] frame_cnt1_q, frame_cnt1_d;

    always_ff @(posedge eth_clk) begin
        if (sys_rst156) begin
            frame_cnt0_q <= '0;
            frame_cnt1_q <= '0;
        end else begin
            frame_cnt0_q <= frame_cnt0_d;
            frame_cnt1_q <= frame_cnt1_d;
        end
    end

    // Errored (tuser) frames count as forwarded frames as well.
    always_comb begin
        frame_cnt0_d = frame_cnt0_q;
        frame_cnt1_d = frame_cnt1_q;
        if (state_q == GNT0 && s0_tvalid && eth_tx_tready && s0_tlast)
            frame_cnt0_d = frame_cnt0_q + CNT_WIDTH'(1);
        if (state_q == GNT1 && s1_tvalid && eth_tx_tready && s1_tlast)
            frame_cnt1_d = frame_cnt1_q + CNT_WIDTH'(1);
    end

    assign frame_cnt0 = frame_cnt0_q;
    assign frame_cnt1 = frame_cnt1_q;
`else
    assign frame_cnt0 = '0;
    assign frame_cnt1 = '0;
`endif

endmodule
